mipi_csi_raw10_depacker: RTL and testbench
==========================================

# mipi_csi_raw10_depacker

Unpacks the RAW10 payload stream produced by `mipi_csi_packet_decoder` into 10-bit pixels, four pixels per output beat. It sits directly downstream of the packet decoder. It consumes its 32-bit payload words and valid flag, and feeds the debayer/line-buffer stage. It also flags packet end and packets whose byte count is not a whole number of 5-byte RAW10 groups.

## Interface
Parameters: none (lane width fixed at 4 bytes, format fixed at RAW10).

- clk_i  input  1  byte clock, same domain as packet decoder
- reset_i  input  1  asynchronous, active-high reset
- data_valid_i  input  1  payload word valid (decoder `output_valid_o`); high for the whole packet payload, low between packets
- data_i  input  32  payload word; `data_i[7:0]` is the earliest byte in stream order, `data_i[31:24]` the latest
- output_valid_o  output  1  `pixel_data_o` holds four valid pixels this cycle
- pixel_data_o  output  40  four pixels: P0 = [9:0], P1 = [19:10], P2 = [29:20], P3 = [39:30]
- line_end_o  output  1  one-cycle pulse marking the end of a payload packet
- align_error_o  output  1  one-cycle pulse, coincident with `line_end_o`, when the packet ended mid-group

## Operation
- RAW10 group format: 5 bytes B0..B4.
  - Pixel Pn = {Bn, B4[2n+1:2n]} for n = 0..3.
  - The MSBs come from Bn; the 2 LSBs come from the packed fifth byte.
- Internal state:
  - `phase` counter, 0..4, wraps from 4 to 0.
  - Residue register holding up to 3 leftover bytes.
  - Registered copy of the previous `data_valid_i`.
- On each rising edge with `data_valid_i` = 1, the new word is appended to the residue bytes (residue first, in stream order). The `phase` column below is the value before the edge.
  - phase 0: 4 bytes available, no group. Residue = the 4 bytes. Output invalid.
  - phase 1: 4 residue + 4 new. Group = residue[3:0] + new byte0. Residue = new bytes 1..3.
  - phase 2: 3 + 4. Group = residue + new bytes 0..1. Residue = new bytes 2..3.
  - phase 3: 2 + 4. Group = residue + new bytes 0..2. Residue = new byte 3.
  - phase 4: 1 + 4. Group = residue + new bytes 0..3. Residue empty.
  - After every accepted word, `phase` = (phase + 1) mod 5.
- Throughput:
  - 5 input words yield exactly 4 output beats (20 bytes = 16 pixels).
  - Output beats occur for input phases 1, 2, 3 and 4.
- With `data_valid_i` = 0:
  - `phase` is forced to 0 and the residue is cleared.
  - `output_valid_o` is 0.
  - Every packet therefore starts aligned at phase 0.
- End of packet:
  - Condition: `data_valid_i` sampled 0 while the previous sample was 1.
  - On that edge `line_end_o` is registered to 1 for one cycle.
  - `align_error_o` is registered to 1 in the same cycle if `phase` ≠ 0 at that edge. Residual bytes are discarded and produce no output.
- `pixel_data_o` holds its last value while `output_valid_o` = 0. It is only defined when `output_valid_o` = 1.
- Reset (asynchronous, may occur at any point, including mid-packet):
  - `output_valid_o`, `line_end_o`, `align_error_o` = 0.
  - `pixel_data_o` = 40'h0.
  - `phase` = 0, residue = 0, previous-valid register = 0.
  - After release, the first word with `data_valid_i` = 1 is treated as phase 0.
  - No `line_end_o` is generated for a packet cut by reset.

## Timing
- All outputs are registered.
- Latency: a group completed by the word sampled at edge k appears on `pixel_data_o` with `output_valid_o` = 1 during the cycle after edge k.
- Continuous valid pattern, from the first payload word: `output_valid_o` sequence is 0,1,1,1,1 repeating, offset by one cycle from the input.
- `line_end_o` and `align_error_o` are high in the cycle after the first edge that samples `data_valid_i` = 0. This never overlaps an `output_valid_o` beat of the same packet.
- Back-to-back packets need at least one invalid cycle between them. That cycle is the packet boundary.
- No backpressure: the downstream stage must accept every valid beat.

## Test plan
- Single group:
  - Stimulus: words 32'h04030201, 32'h0807_06FF, then 3 more words, then valid low.
  - Required: first beat `pixel_data_o` = 40'h4C0F02C07 (P0 = 0x007, P1 = 0x00B, P2 = 0x00F, P3 = 0x013), one cycle after the second word.
- All-ones packet:
  - Stimulus: 10 words of 32'hFFFFFFFF, then valid low.
  - Required: 8 beats of 40'hFFFFFFFFFF, valid pattern 0,1,1,1,1,0,1,1,1,1, then one `line_end_o` pulse and `align_error_o` = 0.
- Misaligned end:
  - Stimulus: 3 words of 32'h00000000, then valid low.
  - Required: exactly 2 output beats, then `line_end_o` and `align_error_o` both pulse high for one cycle together.
- Back-to-back packets:
  - Stimulus: 7 words, 1 idle cycle, 5 words with the single-group pattern.
  - Required: second packet's first beat = 40'h4C0F02C07, so the residue was cleared at the boundary. First packet raises `align_error_o` (7 mod 5 ≠ 0); second does not.
- Reset mid-packet:
  - Stimulus: assert `reset_i` asynchronously after 2 words, release, then send a 5-word packet.
  - Required: all outputs 0 immediately on assertion, no `line_end_o` for the cut packet, and the new packet yields 4 correctly unpacked beats.
- Idle stream:
  - Stimulus: `data_valid_i` = 0 with random `data_i` for 50 cycles after reset.
  - Required: `output_valid_o`, `line_end_o`, `align_error_o` stay 0 throughout.

Source files
------------

// File: rtl/mipi_csi_raw10_depacker_if.sv
// Payload-in / pixel-out bundle between the CSI packet decoder and the debayer stage.
// Signal suffixes are named from the depacker's point of view.
interface mipi_csi_raw10_depacker_if;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        output_valid_o;
  logic [39:0] pixel_data_o;
  logic        line_end_o;
  logic        align_error_o;

  modport master (
    output data_valid_i,
    output data_i,
    input  output_valid_o,
    input  pixel_data_o,
    input  line_end_o,
    input  align_error_o
  );

  modport slave (
    input  data_valid_i,
    input  data_i,
    output output_valid_o,
    output pixel_data_o,
    output line_end_o,
    output align_error_o
  );
endinterface

// File: rtl/mipi_csi_raw10_depacker.sv
// RAW10 depacker: regroups 32-bit payload words into 5-byte groups and emits four
// 10-bit pixels per group, plus end-of-packet and misaligned-end pulses.
module mipi_csi_raw10_depacker (
  input  logic                              clk_i,
  input  logic                              reset_i,
  mipi_csi_raw10_depacker_if.slave          bus_if
);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_t;

  // Pn = {Bn, B4[2n+1:2n]}; byte n of the group sits at bits [8n+7:8n].
  function automatic logic [39:0] unpack_group(input logic [39:0] group);
    logic [39:0] pix;
    pix = 40'h0;
    for (int n = 0; n < 4; n++) begin
      pix[10*n +: 10] = {group[8*n +: 8], group[32 + 2*n +: 2]};
    end
    return pix;
  endfunction

  phase_t      phase_q, phase_d;
  logic [31:0] residue_q, residue_d;
  logic        prev_valid_q;
  logic        out_valid_q, out_valid_d;
  logic [39:0] pixel_q, pixel_d;
  logic        line_end_q, line_end_d;
  logic        align_err_q, align_err_d;
  logic [39:0] group_s;
  logic        group_valid_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= PH0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase only advances on accepted words; any idle cycle realigns to PH0.
  always_comb begin
    phase_d = PH0;
    if (bus_if.data_valid_i) begin
      case (phase_q)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        PH2:     phase_d = PH3;
        PH3:     phase_d = PH4;
        PH4:     phase_d = PH0;
        default: phase_d = PH0;
      endcase
    end else begin
      phase_d = PH0;
    end
  end

  always_comb begin
    group_s       = 40'h0;
    group_valid_s = 1'b0;
    residue_d     = residue_q;
    if (bus_if.data_valid_i) begin
      case (phase_q)
        PH0: begin
          residue_d = bus_if.data_i;
        end
        PH1: begin
          group_s       = {bus_if.data_i[7:0], residue_q};
          group_valid_s = 1'b1;
          residue_d     = {8'h00, bus_if.data_i[31:8]};
        end
        PH2: begin
          group_s       = {bus_if.data_i[15:0], residue_q[23:0]};
          group_valid_s = 1'b1;
          residue_d     = {16'h0000, bus_if.data_i[31:16]};
        end
        PH3: begin
          group_s       = {bus_if.data_i[23:0], residue_q[15:0]};
          group_valid_s = 1'b1;
          residue_d     = {24'h000000, bus_if.data_i[31:24]};
        end
        PH4: begin
          group_s       = {bus_if.data_i, residue_q[7:0]};
          group_valid_s = 1'b1;
          residue_d     = 32'h0;
        end
        default: begin
          residue_d = 32'h0;
        end
      endcase
    end else begin
      residue_d = 32'h0;
    end

    out_valid_d = group_valid_s;
    if (group_valid_s) begin
      pixel_d = unpack_group(group_s);
    end else begin
      pixel_d = pixel_q;
    end

    // Falling edge of the sampled valid marks the packet boundary; leftover bytes are dropped.
    line_end_d  = prev_valid_q & ~bus_if.data_valid_i;
    align_err_d = line_end_d & (phase_q != PH0);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      residue_q    <= 32'h0;
      prev_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      pixel_q      <= 40'h0;
      line_end_q   <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      residue_q    <= residue_d;
      prev_valid_q <= bus_if.data_valid_i;
      out_valid_q  <= out_valid_d;
      pixel_q      <= pixel_d;
      line_end_q   <= line_end_d;
      align_err_q  <= align_err_d;
    end
  end

  assign bus_if.output_valid_o = out_valid_q;
  assign bus_if.pixel_data_o   = pixel_q;
  assign bus_if.line_end_o     = line_end_q;
  assign bus_if.align_error_o  = align_err_q;

endmodule

// File: tb/tb_mipi_csi_raw10_depacker.sv
// Directed bench for the RAW10 depacker; a byte-stream model fills a scoreboard of
// expected pixel beats that is drained whenever the DUT raises output_valid_o.
module tb_mipi_csi_raw10_depacker;

  logic clk;
  logic rst;

  mipi_csi_raw10_depacker_if bus ();

  mipi_csi_raw10_depacker dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          beat_cnt  = 0;
  logic [7:0]  bq[$];
  logic [39:0] sb[$];
  logic        m_prev    = 1'b0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [39:0] model_pixels(input logic [7:0] b [5]);
    logic [39:0] p;
    p = 40'h0;
    for (int n = 0; n < 4; n++) begin
      p[10*n +: 10] = {b[n], b[4][2*n +: 2]};
    end
    return p;
  endfunction

  // Drive one cycle of input, predict from the byte stream, then check the registered outputs.
  task automatic send(input logic v, input logic [31:0] d);
    logic        exp_le;
    logic        exp_ae;
    logic        exp_ov;
    logic [7:0]  g [5];
    logic [39:0] exp_pix;
    exp_le = m_prev && !v;
    exp_ae = exp_le && (bq.size() != 0);
    exp_ov = 1'b0;
    if (v) begin
      for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
      if (bq.size() >= 5) begin
        for (int i = 0; i < 5; i++) g[i] = bq.pop_front();
        sb.push_back(model_pixels(g));
        exp_ov = 1'b1;
      end
    end else begin
      bq.delete();
    end
    m_prev = v;
    bus.data_valid_i = v;
    bus.data_i       = d;
    @(posedge clk);
    #1;
    chk("output_valid", {39'h0, bus.output_valid_o}, {39'h0, exp_ov});
    chk("line_end", {39'h0, bus.line_end_o}, {39'h0, exp_le});
    chk("align_error", {39'h0, bus.align_error_o}, {39'h0, exp_ae});
    if (bus.output_valid_o === 1'b1) begin
      beat_cnt++;
      exp_pix = (sb.size() != 0) ? sb.pop_front() : 40'hx;
      chk("pixel_data", bus.pixel_data_o, exp_pix);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ov"},  {39'h0, bus.output_valid_o}, 40'h0);
    chk({tag, "_le"},  {39'h0, bus.line_end_o},     40'h0);
    chk({tag, "_ae"},  {39'h0, bus.align_error_o},  40'h0);
    chk({tag, "_pix"}, bus.pixel_data_o,            40'h0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.data_valid_i = 1'b0;
    bus.data_i       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #4 rst = 1'b0;

    // Idle stream with random data
    for (int i = 0; i < 50; i++) send(1'b0, $urandom());

    // Single group
    beat_cnt = 0;
    send(1'b1, 32'h04030201);
    send(1'b1, 32'h080706FF);
    chk("single_first_beat", bus.pixel_data_o, 40'h4C0F02C07);
    for (int i = 0; i < 3; i++) send(1'b1, $urandom());
    send(1'b0, 32'h0);
    chk("single_beats", beat_cnt, 40'd4);

    // All-ones packet, 10 words -> 8 beats, aligned end
    beat_cnt = 0;
    for (int i = 0; i < 10; i++) send(1'b1, 32'hFFFFFFFF);
    send(1'b0, 32'h0);
    chk("ones_beats", beat_cnt, 40'd8);
    chk("ones_last_pix", bus.pixel_data_o, 40'hFFFFFFFFFF);
    send(1'b0, 32'h0);

    // Misaligned end: 3 words -> 2 beats, then line_end with align_error
    beat_cnt = 0;
    for (int i = 0; i < 3; i++) send(1'b1, 32'h00000000);
    send(1'b0, 32'h0);
    chk("misalign_beats", beat_cnt, 40'd2);
    chk("misalign_le", {39'h0, bus.line_end_o}, 40'd1);
    chk("misalign_ae", {39'h0, bus.align_error_o}, 40'd1);
    send(1'b0, 32'h0);

    // Back-to-back: 7 words, 1 idle, single-group packet
    for (int i = 0; i < 7; i++) send(1'b1, $urandom());
    send(1'b0, 32'h0);
    chk("b2b_first_ae", {39'h0, bus.align_error_o}, 40'd1);
    send(1'b1, 32'h04030201);
    send(1'b1, 32'h080706FF);
    chk("b2b_second_first_beat", bus.pixel_data_o, 40'h4C0F02C07);
    for (int i = 0; i < 3; i++) send(1'b1, $urandom());
    send(1'b0, 32'h0);
    chk("b2b_second_ae", {39'h0, bus.align_error_o}, 40'd0);
    send(1'b0, 32'h0);

    // Reset mid-packet (asserted between edges while a beat is being presented)
    send(1'b1, 32'h11223344);
    send(1'b1, 32'h55667788);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    bq.delete();
    sb.delete();
    m_prev           = 1'b0;
    bus.data_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("reset_hold");
    #4 rst = 1'b0;
    send(1'b0, 32'h0);
    beat_cnt = 0;
    for (int i = 0; i < 5; i++) send(1'b1, $urandom());
    send(1'b0, 32'h0);
    chk("post_reset_beats", beat_cnt, 40'd4);
    send(1'b0, 32'h0);

    chk("scoreboard_empty", sb.size(), 40'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
